// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding/bypass network
package fwd_pkg;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_RF = '0;
    // Per-entry status; waddr/data are width-parameterised and kept alongside in the top
    typedef struct packed {
        logic valid;
        logic rdy;
    } fwd_entry_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority lookup of one source register against all in-flight entries
// Ports: valid/rdy/waddr/data = entry state (entry 0 youngest), addr/rf = source address and
// register-file value; q = forwarded operand, sel = 0 for register file or k for entry k-1,
// stall = winning entry is not ready yet.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH-1:0]        rdy,
    input  logic [DEPTH*REG_AW-1:0] waddr,
    input  logic [DEPTH*DATA_W-1:0] data,
    input  logic [REG_AW-1:0]       addr,
    input  logic [DATA_W-1:0]       rf,
    output logic [DATA_W-1:0]       q,
    output logic [SEL_W-1:0]        sel,
    output logic                    stall
);
    // Walk oldest to youngest so the youngest hit is the one left standing
    always_comb begin
        q = rf;
        sel = SEL_RF;
        stall = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (valid[i] && waddr[i*REG_AW +: REG_AW] == addr && addr != '0) begin
                q = data[i*DATA_W +: DATA_W];
                sel = SEL_W'(i + 1);
                stall = ~rdy[i];
            end
    end
endmodule

// File: rtl/fwd_bypass_net.sv
// fwd_bypass_net: in-flight result tracker with zero-latency operand forwarding and load-use stall
// Ports: clk/resetn (sync active-low); adv shifts entries; flush/in_* describe the incoming result;
// ld_done/ld_data complete the load sitting in entry 1; src_addr/rf_data are packed per-source
// lookups; src_data/src_sel/stall are the forwarding results. Optional FWD_STATS_EN adds stall_cnt.
module fwd_bypass_net
    import fwd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      adv,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [REG_AW-1:0]         in_waddr,
    input  logic [DATA_W-1:0]         in_wdata,
    input  logic                      in_rdy,
    input  logic                      ld_done,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] rf_data,
    output logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC*SEL_W-1:0]  src_sel,
    output logic                      stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);
    // Index of the load-completion slot, clamped so DEPTH=1 still elaborates
    localparam int LD = DEPTH > 1 ? 1 : 0;
    fwd_entry_t [DEPTH-1:0]             fl, fl_n;
    logic       [DEPTH-1:0][REG_AW-1:0] wa, wa_n;
    logic       [DEPTH-1:0][DATA_W-1:0] dat, dat_n;
    logic       [DEPTH-1:0]             vld, rdy;
    logic       [NUM_SRC-1:0]           st;
    // Load completion is applied first so the filled value shifts along with its entry
    always_comb begin
        fl_n = fl;
        wa_n = wa;
        dat_n = dat;
        if (DEPTH > 1 && ld_done && fl[LD].valid && !fl[LD].rdy) begin
            fl_n[LD].rdy = 1'b1;
            dat_n[LD] = ld_data;
        end
        if (adv) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                fl_n[i] = fl_n[i-1];
                wa_n[i] = wa_n[i-1];
                dat_n[i] = dat_n[i-1];
            end
            fl_n[0].valid = in_valid & ~flush & (in_waddr != '0);
            fl_n[0].rdy = in_rdy;
            wa_n[0] = in_waddr;
            dat_n[0] = in_wdata;
        end
    end
    always_ff @(posedge clk) begin
        fl <= resetn ? fl_n : '0;
        wa <= wa_n;
        dat <= dat_n;
    end
    always_comb begin
        vld = '0;
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = fl[i].valid;
            rdy[i] = fl[i].rdy;
        end
    end
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_match (
            .valid (vld),
            .rdy   (rdy),
            .waddr (wa),
            .data  (dat),
            .addr  (src_addr[s*REG_AW +: REG_AW]),
            .rf    (rf_data[s*DATA_W +: DATA_W]),
            .q     (src_data[s*DATA_W +: DATA_W]),
            .sel   (src_sel[s*SEL_W +: SEL_W]),
            .stall (st[s])
        );
    end
    assign stall = |st;
`ifdef FWD_STATS_EN
    always_ff @(posedge clk)
        stall_cnt <= !resetn ? '0 : (stall && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;
`endif
endmodule

// File: tb/tb_fwd_bypass_net.sv
// tb_fwd_bypass_net: directed and randomized checks of fwd_bypass_net against a queue model
module tb_fwd_bypass_net;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int N  = 2;

    typedef struct {
        bit          v;
        bit [AW-1:0] a;
        bit [DW-1:0] d;
        bit          r;
    } ent_t;

    logic            clk = 1'b0;
    logic            resetn, adv, flush, in_valid, in_rdy, ld_done, stall;
    logic [AW-1:0]   in_waddr;
    logic [DW-1:0]   in_wdata, ld_data;
    logic [N*AW-1:0] src_addr;
    logic [N*DW-1:0] rf_data, src_data;
    logic [N*3-1:0]  src_sel;
`ifdef FWD_STATS_EN
    logic [31:0]     stall_cnt;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    ent_t mq[$];

    fwd_bypass_net #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .NUM_SRC(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .adv       (adv),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_waddr  (in_waddr),
        .in_wdata  (in_wdata),
        .in_rdy    (in_rdy),
        .ld_done   (ld_done),
        .ld_data   (ld_data),
        .src_addr  (src_addr),
        .rf_data   (rf_data),
        .src_data  (src_data),
        .src_sel   (src_sel),
        .stall     (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: queue of in-flight results, index 0 youngest, fixed length D
    task automatic model_edge();
        ent_t e;
        if (!resetn) begin
            foreach (mq[i]) begin
                mq[i].v = 0;
                mq[i].r = 0;
            end
            return;
        end
        if (D > 1 && ld_done && mq[1].v && !mq[1].r) begin
            mq[1].d = ld_data;
            mq[1].r = 1;
        end
        if (adv) begin
            e.v = in_valid && !flush && in_waddr != 0;
            e.a = in_waddr;
            e.d = in_wdata;
            e.r = in_rdy;
            mq.push_front(e);
            void'(mq.pop_back());
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        adv = 0;
        flush = 0;
        in_valid = 0;
        ld_done = 0;
    endtask

    task automatic check(input string tag);
        logic [N*DW-1:0] ed;
        logic [N*3-1:0]  es;
        logic            est;
        #1;
        ed = rf_data;
        es = '0;
        est = 0;
        for (int s = 0; s < N; s++) begin
            logic [AW-1:0] a;
            a = src_addr[s*AW +: AW];
            if (a != 0)
                for (int i = 0; i < D; i++)
                    if (mq[i].v && mq[i].a == a) begin
                        ed[s*DW +: DW] = mq[i].d;
                        es[s*3 +: 3] = 3'(i + 1);
                        if (!mq[i].r) est = 1;
                        break;
                    end
        end
        chk({tag, ".sel"}, 64'(src_sel), 64'(es));
        chk({tag, ".data"}, 64'(src_data), 64'(ed));
        chk({tag, ".stall"}, 64'(stall), 64'(est));
    endtask

    task automatic push(input bit [AW-1:0] a, input bit [DW-1:0] d, input bit r);
        adv = 1;
        in_valid = 1;
        in_waddr = a;
        in_wdata = d;
        in_rdy = r;
        cycle();
    endtask

    task automatic bubble();
        adv = 1;
        in_valid = 0;
        cycle();
    endtask

    initial begin
        ent_t z;
        z = '{v: 0, a: 0, d: 0, r: 0};
        repeat (D) mq.push_back(z);
        resetn = 0; adv = 1; flush = 0; in_valid = 1; in_waddr = 5; in_wdata = 1; in_rdy = 1;
        ld_done = 1; ld_data = 0; src_addr = {5'd5, 5'd3}; rf_data = {32'hA, 32'hB};
        cycle();
        cycle();
        resetn = 1;
        check("reset");
        chk("reset.data_const", 64'(src_data), {32'hA, 32'hB});

        push(3, 32'h11, 1);
        push(3, 32'h22, 1);
        src_addr = {5'd0, 5'd3};
        check("youngest");
        chk("youngest.sel0", 64'(src_sel[2:0]), 64'd1);
        chk("youngest.data0", 64'(src_data[31:0]), 64'h22);

        push(7, 32'h0, 0);
        src_addr = {5'd3, 5'd7};
        check("load_pend");
        chk("load_pend.stall", 64'(stall), 64'd1);
        bubble();
        check("load_e1");
        ld_done = 1; ld_data = 32'h55; adv = 1; in_valid = 0;
        cycle();
        check("load_done");
        chk("load_done.sel0", 64'(src_sel[2:0]), 64'd3);
        chk("load_done.data0", 64'(src_data[31:0]), 64'h55);
        chk("load_done.stall", 64'(stall), 64'd0);

        push(0, 32'hFF, 1);
        src_addr = {5'd0, 5'd0}; rf_data = {32'h1234, 32'h5678};
        check("r0");
        chk("r0.sel", 64'(src_sel), 64'd0);
        flush = 1;
        push(4, 32'h44, 1);
        src_addr = {5'd4, 5'd4};
        check("flush");
        chk("flush.sel", 64'(src_sel), 64'd0);

        push(9, 32'h99, 1);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_waddr = 9; in_wdata = 32'hDEAD; flush = 0; ld_done = 1;
            cycle();
        end
        src_addr = {5'd0, 5'd9};
        check("hold");
        chk("hold.sel0", 64'(src_sel[2:0]), 64'd1);
        chk("hold.data0", 64'(src_data[31:0]), 64'h99);
        repeat (D + 1) bubble();
        check("aged");
        chk("aged.sel", 64'(src_sel), 64'd0);

`ifdef FWD_STATS_EN
        resetn = 0;
        cycle();
        resetn = 1;
        chk("cnt.reset", 64'(stall_cnt), 64'd0);
        src_addr = {5'd0, 5'd0};
        push(7, 32'h0, 0);
        src_addr = {5'd0, 5'd7};
        repeat (5) cycle();
        chk("cnt.five", 64'(stall_cnt), 64'd5);
        resetn = 0;
        cycle();
        resetn = 1;
        chk("cnt.clear", 64'(stall_cnt), 64'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            resetn = ($urandom_range(0, 39) != 0);
            adv = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 7) == 0;
            in_valid = $urandom_range(0, 4) != 0;
            in_waddr = AW'($urandom_range(0, 7));
            in_wdata = $urandom;
            in_rdy = $urandom_range(0, 2) != 0;
            ld_done = $urandom_range(0, 1) != 0;
            ld_data = $urandom;
            cycle();
            src_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            rf_data = {$urandom, $urandom};
            check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
